// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Multiply is unsigned shift-add on operand magnitudes; divide is restoring
// division. Signs are reapplied in a single FIX cycle before HI/LO update.
// Optional build macro MULT_DIV_EARLY_TERM_EN: multiply exits as soon as the
// remaining multiplier bits are all zero (results unchanged, latency shorter).
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_mult_en,
    input  logic             div_mult_signed,
    input  logic [1:0]       div_mult_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    // Two's-complement magnitude of a value whose sign has already been decided.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return s ? neg_w(v) : v;
    endfunction

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               sa_q, sb_q, is_div_q, done_q;
    logic [WIDTH-1:0]   a_q, mplier_q, divisor_q, rem_q, quo_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] mcand_q, prod_q;

    logic               start_d, last_iter_d, mul_last_d;
    logic               sa_d, sb_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     shifted_d, diff_d;
    logic [WIDTH-1:0]   rem_d, quo_d, fix_hi_d, fix_lo_d;

    // Per-iteration datapath steps and the sign-corrected final result.
    always_comb begin
        start_d     = (state_q == IDLE) && div_mult_en && div_mult_op[1];
        sa_d        = op_a[WIDTH-1] & div_mult_signed;
        sb_d        = op_b[WIDTH-1] & div_mult_signed;
        prod_d      = mplier_q[0] ? prod_q + mcand_q : prod_q;
        shifted_d   = {rem_q, quo_q[WIDTH-1]};
        diff_d      = shifted_d - {1'b0, divisor_q};
        rem_d       = diff_d[WIDTH] ? shifted_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
        quo_d       = {quo_q[WIDTH-2:0], ~diff_d[WIDTH]};
        last_iter_d = (cnt_q == CW'(WIDTH - 1));
`ifdef MULT_DIV_EARLY_TERM_EN
        // Bit 0 is consumed this cycle; nothing left above it means no more adds.
        mul_last_d  = last_iter_d || (mplier_q[WIDTH-1:1] == '0);
`else
        mul_last_d  = last_iter_d;
`endif
        fix_hi_d = '0;
        fix_lo_d = '0;
        if (!is_div_q) begin
            {fix_hi_d, fix_lo_d} = (sa_q ^ sb_q) ? neg_2w(prod_q) : prod_q;
        end else if (divisor_q == '0) begin
            // Divide by zero returns the original dividend in HI and all ones in LO.
            fix_hi_d = a_q;
            fix_lo_d = '1;
        end else begin
            fix_lo_d = (sa_q ^ sb_q) ? neg_w(quo_q) : quo_q;
            fix_hi_d = sa_q ? neg_w(rem_q) : rem_q;
        end
    end

    // Control FSM plus iteration state and the HI/LO registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            is_div_q  <= 1'b0;
            done_q    <= 1'b0;
            a_q       <= '0;
            mplier_q  <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_d) begin
                        sa_q      <= sa_d;
                        sb_q      <= sb_d;
                        is_div_q  <= div_mult_op[0];
                        a_q       <= op_a;
                        mcand_q   <= {{WIDTH{1'b0}}, mag(op_a, sa_d)};
                        mplier_q  <= mag(op_b, sb_d);
                        prod_q    <= '0;
                        quo_q     <= mag(op_a, sa_d);
                        rem_q     <= '0;
                        divisor_q <= mag(op_b, sb_d);
                        cnt_q     <= '0;
                        state_q   <= div_mult_op[0] ? DIV : MUL;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (mul_last_d) state_q <= FIX;
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter_d) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases, interference, reset
// abort and random operations compared against a plain-arithmetic model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, en, sgn, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_err    = 0;
    logic [W-1:0] hi_m, lo_m;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .div_mult_en(en), .div_mult_signed(sgn),
        .div_mult_op(op), .op_a(a), .op_b(b), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: full-width arithmetic on the architectural values; lat is the
    // number of clock edges from the start edge until done is seen.
    task automatic model(input logic [1:0] o, input logic s, input logic [W-1:0] x,
                         input logic [W-1:0] y, output logic [W-1:0] eh,
                         output logic [W-1:0] el, output int lat);
        logic [63:0] p;
        int xi, yi, n;
        n = W;
        if (o == 2'b10) begin
            if (s) p = longint'($signed(x)) * longint'($signed(y));
            else   p = {32'b0, x} * {32'b0, y};
            eh = p[63:32];
            el = p[31:0];
`ifdef MULT_DIV_EARLY_TERM_EN
            begin
                logic [W-1:0] mb;
                mb = (s && y[W-1]) ? -y : y;
                n = 1;
                for (int i = 0; i < W; i++) if (mb[i]) n = i + 1;
            end
`endif
        end else if (y == 0) begin
            eh = x;
            el = '1;
        end else if (s) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                el = 32'h8000_0000;
                eh = 0;
            end else begin
                xi = $signed(x);
                yi = $signed(y);
                el = xi / yi;
                eh = xi % yi;
            end
        end else begin
            el = x / y;
            eh = x % y;
        end
        lat = n + 1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit interfere, input bit wr_start,
                          input bit chain, input string tag);
        logic [W-1:0] eh, el;
        int lat, edges;
        bit stable, got;
        model(o, s, x, y, eh, el, lat);
        @(negedge clk);
        en = 1'b1; op = o; sgn = s; a = x; b = y;
        if (wr_start) begin
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        end
        @(posedge clk); #1;
        en = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'b00;
        a = $urandom; b = $urandom;
        chk1({tag, "_busy_start"}, busy, 1'b1);
        edges = 0; stable = 1; got = 0;
        while (edges < 80 && !got) begin
            if (hi !== hi_m || lo !== lo_m || busy !== 1'b1) stable = 0;
            if (interfere && edges == 4) begin
                en = 1'b1; op = 2'b10; hi_we = 1'b1; wdata = 32'h0000_00AA;
            end
            if (interfere && edges == 5) begin
                en = 1'b0; hi_we = 1'b0; op = 2'b00;
            end
            @(posedge clk); #1;
            edges++;
            if (done === 1'b1) got = 1;
        end
        chki({tag, "_latency"}, edges, lat);
        chk1({tag, "_busy_done"}, busy, 1'b0);
        chkw({tag, "_hi"}, hi, eh);
        chkw({tag, "_lo"}, lo, el);
        chk1({tag, "_hold"}, stable, 1'b1);
        hi_m = eh;
        lo_m = el;
        if (!chain) begin
            @(posedge clk); #1;
            chk1({tag, "_done_pulse"}, done, 1'b0);
        end
    endtask

    initial begin
        bit seen;
        logic [1:0]   ro;
        logic         rs;
        logic [W-1:0] rx, ry;

        reset = 1'b0; en = 1'b0; sgn = 1'b0; op = 2'b00; hi_we = 1'b0; lo_we = 1'b0;
        a = '0; b = '0; wdata = '0;
        hi_m = '0; lo_m = '0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chkw("rst_hi", hi, '0);
        chkw("rst_lo", lo, '0);
        reset = 1'b1;

        run_op(2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0, "umul");
        chkw("umul_hi_const", hi, 32'h0000_0001);
        chkw("umul_lo_const", lo, 32'hFFFF_FFFE);
        run_op(2'b10, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0, 0, "smul");
        chkw("smul_lo_const", lo, 32'hFFFF_FFEB);
        run_op(2'b11, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0, "sdiv");
        chkw("sdiv_lo_const", lo, 32'hFFFF_FFFD);
        chkw("sdiv_hi_const", hi, 32'hFFFF_FFFF);
        run_op(2'b11, 1'b0, 32'h1234_5678, 32'h0000_0000, 0, 0, 0, "divu0");
        run_op(2'b11, 1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 0, 0, 0, "sdiv0");
        run_op(2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "sdivovf");
        run_op(2'b10, 1'b1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, "smulmin");
        run_op(2'b10, 1'b0, 32'h0000_0005, 32'h0000_0001, 0, 0, 0, "mul5x1");
        run_op(2'b10, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 1, 0, 0, "interf");
        run_op(2'b11, 1'b0, 32'h0000_0064, 32'h0000_0007, 0, 1, 0, "wr_start");

        // Ignored op codes must not start anything.
        @(negedge clk); en = 1'b1; op = 2'b01; sgn = 1'b1;
        @(posedge clk); #1;
        chk1("nop01_busy", busy, 1'b0);
        op = 2'b00;
        @(posedge clk); #1;
        chk1("nop00_busy", busy, 1'b0);
        en = 1'b0;

        // MTLO then MTHI+MTLO together in IDLE.
        @(negedge clk); lo_we = 1'b1; wdata = 32'h0000_0055;
        @(posedge clk); #1;
        lo_we = 1'b0;
        lo_m = 32'h0000_0055;
        chkw("mtlo_lo", lo, lo_m);
        chkw("mtlo_hi", hi, hi_m);
        @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        hi_m = 32'h0BAD_F00D; lo_m = 32'h0BAD_F00D;
        chkw("mtboth_hi", hi, hi_m);
        chkw("mtboth_lo", lo, lo_m);

        // Reset in the tenth cycle of a divide aborts it.
        @(negedge clk); en = 1'b1; op = 2'b11; sgn = 1'b0; a = 32'h0000_1000; b = 32'h0000_0003;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chkw("abort_hi", hi, '0);
        chkw("abort_lo", lo, '0);
        chk1("abort_busy", busy, 1'b0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen = 1;
        end
        chk1("abort_no_done", seen, 1'b0);
        hi_m = '0; lo_m = '0;

        // Random operations, some issued back-to-back in the done cycle.
        for (int i = 0; i < 30; i++) begin
            ro = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
            rs = 1'($urandom_range(0, 1));
            rx = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       ry = '0;
                1:       ry = 32'($urandom_range(1, 15));
                2:       ry = 32'hFFFF_FFFF;
                default: ry = 32'($urandom);
            endcase
            run_op(ro, rs, rx, ry, 0, 0, (i % 3) == 0, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the multicycle MIPS core.
- Sits directly downstream of the control unit. It consumes div_mult_en, div_mult_signed and div_mult_op, with operands taken from the register-file read ports (rs, rt).
- Provides HI/LO to the datapath for MFHI/MFLO, and a busy flag the state sequencer uses to stall before the next HI/LO access.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- div_mult_en  in  1  start request from control unit.
- div_mult_signed  in  1  1 = signed operation (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- div_mult_op  in  2  2'b10 = multiply, 2'b11 = divide, other codes = no operation.
- op_a  in  WIDTH  rs value: multiplicand or dividend.
- op_b  in  WIDTH  rt value: multiplier or divisor.
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO hold a fresh result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; hi=0, lo=0, busy=0, done=0; internal accumulators cleared.
- Reset mid-operation aborts the operation with no HI/LO update.
- States: IDLE, MUL, DIV, FIX.
- IDLE: a start is accepted when div_mult_en=1 and div_mult_op is 10 or 11.
  - At that edge: latch signs sa=op_a[MSB]&signed and sb=op_b[MSB]&signed.
  - Latch magnitudes (two's-complement negation when the sign bit is set).
  - Clear the iteration counter; go to MUL or DIV.
  - Any other op code is ignored.
- div_mult_en held high for several cycles, or asserted while busy, starts nothing extra. Only the IDLE-cycle request is accepted.
- MUL: unsigned shift-add, one multiplier bit per cycle, producing a 2*WIDTH product.
- DIV: restoring division, one quotient bit per cycle, producing a WIDTH quotient and WIDTH remainder.
- Both MUL and DIV run exactly WIDTH cycles, then go to FIX.
- FIX (one cycle), result written at the exiting edge:
  - Multiply: {hi,lo} = product, negated (2*WIDTH-bit) if sa^sb.
  - Divide: lo = quotient, negated if sa^sb; hi = remainder, negated if sa.
  - Divide by zero: hi=op_a as latched (original value), lo={WIDTH{1}}, regardless of signedness. No exception.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
  - Then go to IDLE.
- Timing: start accepted at edge E. busy=1 for cycles after E through the FIX cycle (WIDTH+1 cycles). done=1 for exactly one cycle after FIX, with busy=0 in that cycle. New HI/LO are visible the same cycle done=1. A new start may be accepted in the done cycle.
- hi_we/lo_we: honoured only in IDLE, written at the edge.
  - While busy the writes are ignored.
  - If a write coincides with an accepted start, the start wins and the write is dropped.
  - hi_we and lo_we may both be 1: both registers take wdata.
- HI/LO keep their old values throughout an operation; no partial results are visible.

Optional Feature:
- Macro: MULT_DIV_EARLY_TERM_EN.
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, skip the remaining iterations and go straight to FIX (the product is unchanged).
  - Multiply latency becomes (index of highest set magnitude bit of op_b)+1 iterations, minimum 1.
  - Divide latency is unchanged.
- Undefined: fixed WIDTH-iteration latency for both operations.
- Results are identical in both builds.

Test Plan:
- Unsigned multiply: op 10, signed=0, a=0xFFFFFFFF, b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE; done exactly 34 cycles after the start edge (without the macro).
- Signed multiply: signed=1, a=0xFFFFFFFD (-3), b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 33 cycles.
- Signed divide: op 11, a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide by zero: DIVU a=0x12345678, b=0 -> hi=0x12345678, lo=0xFFFFFFFF, with normal latency.
- Interference:
  - MTHI wdata=0xAA while busy -> hi is unaffected and shows the final result.
  - div_mult_en re-pulsed mid-operation -> no restart.
  - MTLO wdata=0x55 in IDLE -> lo=0x55 next cycle.
- Reset:
  - reset=0 in cycle 10 of a DIV -> next cycle hi=lo=0, busy=0, done never pulses.
  - With the macro: a=5, b=1 multiply -> done 3 cycles after start, lo=5.
